samples_decim: RTL and testbench
================================

Name: samples_decim

Overview:
- Receive-side counterpart of the transmit upsampler: reduces a sample-rate stream to one value per symbol.
- Two modes:
  - pick mode: take one sample per symbol at a fixed phase.
  - integrate mode: integrate-and-dump, summing every sample of a symbol.
- Sits after the matched filter, ahead of the QAM slicer.
- Accepts sync and phase advance/retard pulses from timing recovery.

Parameters:
- WIDTH, 12: signed input sample width.
- RATIO, 8: samples per symbol; must be >= 2.
- PHASE, 3: sample index picked in pick mode; range 0..RATIO-1.
- SAMPLE_TYPE, 0: 0 = pick one sample per symbol; 1 = integrate-and-dump.
- OW (derived, WIDTH+$clog2(RATIO)): output width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  signed sample.
- in_valid  input  1  data_in carries a sample this cycle.
- sync  input  1  pulse; realigns the symbol boundary.
- phase_adv  input  1  pulse; shorten the next symbol by one sample.
- phase_ret  input  1  pulse; lengthen the next symbol by one discarded sample.
- data_out  output  OW  signed symbol-rate value.
- out_valid  output  1  one-cycle strobe; data_out is new.

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - data_out=0, out_valid=0
  - sample counter cnt=0, accumulator acc=0
  - adv/ret pending flags and the stall flag.
- Reset takes priority over every other input. A symbol or accumulation in progress is abandoned and produces no output.
- cnt runs 0..RATIO-1 and advances only on in_valid cycles. Idle cycles change no state except clearing out_valid.
- out_valid is registered:
  - high exactly one cycle, the cycle after the in_valid cycle that completes selection or dump;
  - 0 in every other cycle.
- data_out holds its last value between strobes.
- Pick mode (SAMPLE_TYPE=0):
  - on in_valid with cnt==PHASE, data_out <= sign-extended data_in and the strobe fires;
  - acc is unused.
- Integrate mode (SAMPLE_TYPE=1):
  - on in_valid, acc <= acc + data_in (signed, OW bits);
  - when cnt==RATIO-1: data_out <= acc + data_in, acc <= 0, strobe fires;
  - OW bits mean RATIO full-scale samples can never overflow.
- Wrap: in_valid with cnt==RATIO-1 gives cnt <= 0, unless a pending flag applies (below).
- Phase pulses:
  - phase_adv and phase_ret each set a one-deep pending flag;
  - a repeat pulse while its flag is set is ignored;
  - flags are consumed only at wrap:
    - adv only: cnt <= 1, so the next symbol has RATIO-1 samples. Integrate sums RATIO-1 samples. In pick mode with PHASE==0 that symbol produces no output.
    - ret only: cnt <= 0 and the stall flag is set. The next in_valid sample is discarded: not counted, accumulated or picked. The stall flag then clears.
    - both pending: both cleared, no adjustment.
  - A pulse arriving in the same cycle as the wrap is latched and applies at the following wrap.
- sync:
  - clears cnt, acc, pending flags and stall;
  - if in_valid is asserted in the same cycle, that sample is processed as cnt=0 of a fresh symbol (accumulated, or picked if PHASE==0), and cnt <= 1 afterwards;
  - sync does not suppress a strobe already registered for this cycle.
- rst overrides sync; sync overrides phase pulses presented in the same cycle.

Test Plan:
- Reset: params WIDTH=8, RATIO=4, PHASE=1. Hold rst 3 cycles with in_valid=1 and data_in=0x7F -> data_out=0, out_valid=0 throughout and on the first cycle after release.
- Pick mode:
  - stimulus: sync together with the first sample, then continuous in_valid with data 0,1,2,...,11;
  - response: out_valid pulses one cycle after samples 1, 5, 9, with data_out = 1, 5, 9 and exactly 3 strobes;
  - repeat with data -3 at index 5 -> data_out = 0x3FD (10-bit sign extension).
- Integrate mode (SAMPLE_TYPE=1):
  - 8 samples of +100 -> two strobes, data_out=400 each;
  - 4 samples of -128 -> data_out=-512 (0x200);
  - in_valid gaps of 0-3 idle cycles between samples -> identical results.
- phase_adv: pulse mid-symbol in integrate mode with all samples +10 -> dumps read 40, 30, 40. Second adv pulse during the pending window -> still only one shortened symbol.
- phase_ret: pulse mid-symbol, samples +10, with the discarded sample = +99:
  - +99 never appears in any dump; sums stay 40;
  - the strobe gap is 5 valid samples;
  - adv and ret in the same symbol -> no change.
- Reset mid-operation: assert rst after 2 samples of an integrate symbol, then release -> no strobe for the partial symbol; the next 4 samples give a full sum, starting from cnt=0.

Source files
------------

// File: rtl/samples_decim.sv
// samples_decim: sample-rate to symbol-rate decimator for the receive path.
// Pick mode keeps one sample per symbol at a fixed phase; integrate mode
// sums every sample of a symbol and dumps the sum. Timing recovery can
// shorten (phase_adv) or lengthen (phase_ret) the next symbol by one sample,
// or realign the symbol boundary outright (sync).
//
// Handshake: in_valid qualifies data_in for the cycle it is high; there is no
// backpressure. out_valid is a registered one-cycle strobe marking a new
// data_out, which otherwise holds its last value.
module samples_decim #(
  parameter  int WIDTH       = 12,
  parameter  int RATIO       = 8,
  parameter  int PHASE       = 3,
  parameter  int SAMPLE_TYPE = 0,
  localparam int OW          = WIDTH + $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic                 in_valid,
  input  logic                 sync,
  input  logic                 phase_adv,
  input  logic                 phase_ret,
  output logic signed [OW-1:0] data_out,
  output logic                 out_valid
);

  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
  localparam logic [CW-1:0] PICK = CW'(PHASE);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [OW-1:0] acc_q, acc_d;
  logic                 adv_q, adv_d;
  logic                 ret_q, ret_d;
  logic                 stall_q, stall_d;
  logic signed [OW-1:0] data_out_q, data_out_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] ext;

  // Next-state: sync realigns, stall drops one sample, wrap consumes pending pulses.
  always_comb begin
    ext         = {{(OW-WIDTH){data_in[WIDTH-1]}}, data_in};
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    adv_d       = adv_q | phase_adv;
    ret_d       = ret_q | phase_ret;
    stall_d     = stall_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    if (sync) begin
      // Fresh symbol; phase pulses in this cycle are dropped.
      cnt_d   = '0;
      acc_d   = '0;
      adv_d   = 1'b0;
      ret_d   = 1'b0;
      stall_d = 1'b0;
      if (in_valid) begin
        cnt_d = ONE;
        if (SAMPLE_TYPE == 0) begin
          if (PHASE == 0) begin
            data_out_d  = ext;
            out_valid_d = 1'b1;
          end
        end else begin
          acc_d = ext;
        end
      end
    end else if (in_valid) begin
      if (stall_q) begin
        // Retard: this sample is thrown away and not counted.
        stall_d = 1'b0;
      end else begin
        if (SAMPLE_TYPE == 0) begin
          if (cnt_q == PICK) begin
            data_out_d  = ext;
            out_valid_d = 1'b1;
          end
        end else if (cnt_q == LAST) begin
          data_out_d  = acc_q + ext;
          acc_d       = '0;
          out_valid_d = 1'b1;
        end else begin
          acc_d = acc_q + ext;
        end
        if (cnt_q == LAST) begin
          // Consume flags from earlier cycles; a pulse now waits for the next wrap.
          adv_d = phase_adv;
          ret_d = phase_ret;
          if (adv_q && !ret_q) begin
            cnt_d = ONE;
          end else if (ret_q && !adv_q) begin
            cnt_d   = '0;
            stall_d = 1'b1;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      adv_q       <= 1'b0;
      ret_q       <= 1'b0;
      stall_q     <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      adv_q       <= adv_d;
      ret_q       <= ret_d;
      stall_q     <= stall_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_samples_decim.sv
// Bench for samples_decim: a pick-mode and an integrate-mode instance share
// one stimulus stream; a symbol-level reference model predicts both outputs.
module tb_samples_decim;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int P  = 1;
  localparam int OW = W + $clog2(R);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                sync = 1'b0;
  logic                in_valid = 1'b0;
  logic                phase_adv = 1'b0;
  logic                phase_ret = 1'b0;
  logic signed [W-1:0] data_in = '0;
  logic signed [OW-1:0] pick_data, int_data;
  logic                pick_valid, int_valid;

  samples_decim #(.WIDTH(W), .RATIO(R), .PHASE(P), .SAMPLE_TYPE(0)) u_pick (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .sync(sync),
    .phase_adv(phase_adv), .phase_ret(phase_ret),
    .data_out(pick_data), .out_valid(pick_valid)
  );

  samples_decim #(.WIDTH(W), .RATIO(R), .PHASE(P), .SAMPLE_TYPE(1)) u_int (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .sync(sync),
    .phase_adv(phase_adv), .phase_ret(phase_ret),
    .data_out(int_data), .out_valid(int_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Holds the samples of the symbol being built; a symbol closes when its
  // position reaches R-1. An advanced symbol starts at position 1.
  int             sym_q[$];
  int             m_first = 0;
  bit             m_skip = 0, m_adv = 0, m_ret = 0;
  bit             m_pv = 0, m_iv = 0;
  logic [OW-1:0]  m_pd = '0, m_id = '0;

  task automatic m_accept(input int d);
    int pos;
    int sum;
    pos = m_first + sym_q.size();
    sym_q.push_back(d);
    if (pos == P) begin
      m_pd = OW'(d);
      m_pv = 1;
    end
    if (pos == R - 1) begin
      sum = 0;
      foreach (sym_q[i]) sum += sym_q[i];
      m_id = OW'(sum);
      m_iv = 1;
      sym_q.delete();
      m_first = (m_adv && !m_ret) ? 1 : 0;
      m_skip  = m_ret && !m_adv;
      m_adv   = 0;
      m_ret   = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit iv, input int d,
                            input bit a, input bit rt);
    m_pv = 0;
    m_iv = 0;
    if (r) begin
      sym_q.delete();
      m_first = 0; m_skip = 0; m_adv = 0; m_ret = 0;
      m_pd = '0; m_id = '0;
    end else if (s) begin
      sym_q.delete();
      m_first = 0; m_skip = 0; m_adv = 0; m_ret = 0;
      if (iv) m_accept(d);
    end else begin
      if (iv) begin
        if (m_skip) m_skip = 0;
        else m_accept(d);
      end
      if (a)  m_adv = 1;
      if (rt) m_ret = 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] int_got[$];
  logic [OW-1:0] pick_got[$];
  int            strobe_at[$];
  int            n_samples = 0;

  task automatic begin_seq();
    exp_q.delete();
    int_got.delete();
    pick_got.delete();
    strobe_at.delete();
    n_samples = 0;
  endtask

  task automatic compare_dumps(input string name);
    check({name, "_count"}, OW'(int_got.size()), OW'(exp_q.size()));
    for (int i = 0; i < int_got.size() && i < exp_q.size(); i++)
      check($sformatf("%s_dump%0d", name, i), int_got[i], exp_q[i]);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit s, input bit iv, input int d,
                      input bit a, input bit rt);
    int dv;
    rst = r; sync = s; in_valid = iv; phase_adv = a; phase_ret = rt;
    data_in = d[W-1:0];
    dv = int'(data_in);
    @(posedge clk);
    model_step(r, s, iv, dv, a, rt);
    if (iv && !r) n_samples++;
    #1;
    check("model_pick_valid", OW'(pick_valid), OW'(m_pv));
    check("model_pick_data", pick_data, m_pd);
    check("model_int_valid", OW'(int_valid), OW'(m_iv));
    check("model_int_data", int_data, m_id);
    if (int_valid) begin
      int_got.push_back(int_data);
      strobe_at.push_back(n_samples);
    end
    if (pick_valid) pick_got.push_back(pick_data);
  endtask

  task automatic sample(input int d);
    step(0, 0, 1, d, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r, s, iv;
    int d;
    bit a, rt;
    bit pv;
    logic [OW-1:0] pd;
    bit ivo;
    logic [OW-1:0] id;
  } vec_t;

  vec_t tbl[$];

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].iv, tbl[i].d, tbl[i].a, tbl[i].rt);
      check($sformatf("tbl%0d_pick_valid", i), OW'(pick_valid), OW'(tbl[i].pv));
      check($sformatf("tbl%0d_pick_data", i), pick_data, tbl[i].pd);
      check($sformatf("tbl%0d_int_valid", i), OW'(int_valid), OW'(tbl[i].ivo));
      check($sformatf("tbl%0d_int_data", i), int_data, tbl[i].id);
    end
  endtask

  initial begin
    logic [OW-1:0] lp, li;
    int blk, d, g0, g1;
    vec_t v;

    // Table: 3 reset cycles with full-scale input, one idle, then two pick runs.
    for (int i = 0; i < 3; i++) begin
      v = '{r:1, s:0, iv:1, d:127, a:0, rt:0, pv:0, pd:'0, ivo:0, id:'0};
      tbl.push_back(v);
    end
    v = '{r:0, s:0, iv:0, d:0, a:0, rt:0, pv:0, pd:'0, ivo:0, id:'0};
    tbl.push_back(v);
    lp = '0; li = '0;
    for (int run = 0; run < 2; run++) begin
      blk = 0;
      for (int k = 0; k < 12; k++) begin
        d = (run == 1 && k == 5) ? -3 : k;
        blk += d;
        v = '{r:0, s:(k == 0), iv:1, d:d, a:0, rt:0, pv:(k % 4 == 1), pd:'0, ivo:(k % 4 == 3), id:'0};
        if (v.pv) lp = OW'(d);
        if (v.ivo) begin
          li = OW'(blk);
          blk = 0;
        end
        v.pd = lp;
        v.id = li;
        tbl.push_back(v);
      end
      v = '{r:0, s:0, iv:0, d:0, a:0, rt:0, pv:0, pd:lp, ivo:0, id:li};
      tbl.push_back(v);
    end

    apply_range(0, 4);
    begin_seq();
    apply_range(4, 17);
    check("pick_run1_strobes", OW'(pick_got.size()), OW'(3));
    begin_seq();
    apply_range(17, 30);
    check("pick_run2_strobes", OW'(pick_got.size()), OW'(3));
    check("pick_signext", pick_got.size() > 1 ? pick_got[1] : '0, 10'h3FD);

    // Integrate: 8 x +100.
    begin_seq();
    step(0, 1, 1, 100, 0, 0);
    for (int i = 0; i < 7; i++) sample(100);
    idle(2);
    exp_q.push_back(OW'(400)); exp_q.push_back(OW'(400));
    compare_dumps("int_100");

    // Integrate: 4 x -128 full scale.
    begin_seq();
    step(0, 1, 1, -128, 0, 0);
    for (int i = 0; i < 3; i++) sample(-128);
    idle(1);
    exp_q.push_back(10'h200);
    compare_dumps("int_neg_full");

    // Integrate with random idle gaps.
    begin_seq();
    step(0, 1, 1, 100, 0, 0);
    for (int i = 0; i < 7; i++) begin
      idle($urandom_range(0, 3));
      sample(100);
    end
    idle(2);
    exp_q.push_back(OW'(400)); exp_q.push_back(OW'(400));
    compare_dumps("int_gaps");

    // Advance, with a repeated pulse while pending.
    begin_seq();
    step(0, 1, 1, 10, 0, 0);
    step(0, 0, 1, 10, 1, 0);
    step(0, 0, 1, 10, 1, 0);
    for (int i = 0; i < 8; i++) sample(10);
    idle(2);
    exp_q.push_back(OW'(40)); exp_q.push_back(OW'(30)); exp_q.push_back(OW'(40));
    compare_dumps("adv");

    // Retard: the sample after the wrap (+99) is discarded.
    begin_seq();
    step(0, 1, 1, 10, 0, 0);
    sample(10);
    step(0, 0, 0, 0, 0, 1);
    sample(10); sample(10);
    sample(99);
    for (int i = 0; i < 8; i++) sample(10);
    idle(2);
    exp_q.push_back(OW'(40)); exp_q.push_back(OW'(40)); exp_q.push_back(OW'(40));
    compare_dumps("ret");
    g0 = strobe_at.size() > 1 ? strobe_at[1] - strobe_at[0] : -1;
    check("ret_gap", OW'(g0), OW'(5));

    // Advance and retard in the same symbol cancel.
    begin_seq();
    step(0, 1, 1, 10, 0, 0);
    step(0, 0, 1, 10, 1, 0);
    step(0, 0, 1, 10, 0, 1);
    for (int i = 0; i < 9; i++) sample(10);
    idle(2);
    exp_q.push_back(OW'(40)); exp_q.push_back(OW'(40)); exp_q.push_back(OW'(40));
    compare_dumps("adv_ret");
    g1 = strobe_at.size() > 1 ? strobe_at[1] - strobe_at[0] : -1;
    check("adv_ret_gap", OW'(g1), OW'(4));

    // Reset in the middle of an integrate symbol.
    begin_seq();
    step(0, 1, 1, 50, 0, 0);
    sample(50);
    step(1, 0, 0, 0, 0, 0);
    check("midrst_out", int_data, '0);
    sample(5); sample(6); sample(7); sample(8);
    idle(2);
    exp_q.push_back(OW'(26));
    compare_dumps("mid_reset");

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
           $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
